// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and constants for the convolution result collector
package cnn_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_e;
  localparam logic [7:0] PIX_MAX = 8'd255;
  function automatic int npix(input int h, input int w);
    return h * w;
  endfunction
endpackage

// File: rtl/conv_pix_buffer.sv
// conv_pix_buffer: DEPTH x 8 dual-port pixel RAM; ports we/waddr/wdata write, re/raddr read with 1-cycle registered rdata_o
module conv_pix_buffer #(
  parameter int DEPTH = 72,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;
  always_ff @(posedge clk) if (we_i) mem[waddr_i] <= wdata_i;
  // read register doubles as the out_data holding register, so it only loads on re_i
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  assign rdata_o = rdata_q;
endmodule

// File: rtl/conv_result_collector.sv
// conv_result_collector: collects every TAPS-th accumulator sample, requantizes to 8 bit into a frame buffer, then streams the frame out (ports: start, in_valid/in_data/in_ready, out_valid/out_ready/out_data/out_last, busy, done, sat)
module conv_result_collector
  import cnn_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int OUT_H = 8,
  parameter int OUT_W = 9,
  parameter int TAPS  = 9,
  parameter int SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [ACC_W-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             sat
);
  localparam int NPIX = npix(OUT_H, OUT_W);
  localparam int TW   = TAPS > 1 ? $clog2(TAPS) : 1;
  localparam int AW   = NPIX > 1 ? $clog2(NPIX) : 1;
  localparam int PW   = $clog2(NPIX + 1);
  state_e state_q, state_d;
  logic [TW-1:0] tap_q;
  logic [PW-1:0] pix_q, rd_q;
  logic ov_q, last_q, sat_q;
  logic acc, fin, ld, clip;
  logic signed [ACC_W-1:0] v;
  logic [7:0] pix;
  assign acc  = in_valid && in_ready && !start;
  assign fin  = acc && tap_q == TW'(TAPS - 1);
  // issue a read whenever the output register is empty or being consumed
  assign ld   = state_q == DRAIN && (!ov_q || out_ready) && rd_q != PW'(NPIX);
  assign v    = $signed(in_data) >>> SHIFT;
  assign clip = !v[ACC_W-1] && |v[ACC_W-2:8];
  assign pix  = v[ACC_W-1] ? 8'd0 : clip ? PIX_MAX : v[7:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = start ? COLLECT :
              (fin && pix_q == PW'(NPIX - 1)) ? DRAIN :
              (state_q == DRAIN && ov_q && out_ready && last_q) ? DONE : state_q;
  always_comb begin
    in_ready = state_q == COLLECT;
    busy     = state_q == COLLECT || state_q == DRAIN;
    done     = state_q == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_q  <= '0;
      pix_q  <= '0;
      rd_q   <= '0;
      ov_q   <= 1'b0;
      last_q <= 1'b0;
      sat_q  <= 1'b0;
    end else if (start) begin
      tap_q  <= '0;
      pix_q  <= '0;
      rd_q   <= '0;
      ov_q   <= 1'b0;
      last_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      if (acc) tap_q <= fin ? '0 : tap_q + TW'(1);
      if (fin) pix_q <= pix_q + PW'(1);
      if (fin && clip) sat_q <= 1'b1;
      if (ld) begin
        rd_q   <= rd_q + PW'(1);
        ov_q   <= 1'b1;
        last_q <= rd_q == PW'(NPIX - 1);
      end else if (ov_q && out_ready) begin
        ov_q   <= 1'b0;
        last_q <= 1'b0;
      end
    end
  end
  conv_pix_buffer #(.DEPTH(NPIX), .AW(AW)) u_buf (
    .clk(clk), .rst(rst),
    .we_i(fin), .waddr_i(pix_q[AW-1:0]), .wdata_i(pix),
    .re_i(ld), .raddr_i(rd_q[AW-1:0]), .rdata_o(out_data)
  );
  assign out_valid = ov_q;
  assign out_last  = last_q;
  assign sat       = sat_q;
endmodule

// File: tb/tb_conv_result_collector.sv
// tb_conv_result_collector: table-driven and scoreboard checks of conv_result_collector
module tb_conv_result_collector;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic in_ready, out_valid, out_last, busy, done, sat;
  logic [7:0] out_data;
  logic s_start = 0, s_in_valid = 0, s_out_ready = 1;
  logic [31:0] s_in_data = 0;
  logic s_in_ready, s_out_valid, s_out_last, s_busy, s_done, s_sat;
  logic [7:0] s_out_data;
  always #5 clk = ~clk;
  conv_result_collector u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .sat(sat));
  conv_result_collector #(.OUT_H(1), .OUT_W(2), .TAPS(1), .SHIFT(4)) u_s4 (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_data(s_in_data),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_last(s_out_last), .busy(s_busy), .done(s_done), .sat(s_sat));
  typedef struct { logic [31:0] d; logic [7:0] px; logic st; } vec_t;
  typedef struct { logic [7:0] d; logic l; } px_t;
  vec_t tbl[5];
  px_t q[$];
  int nvec = 0, nerr = 0, hs_cnt = 0;
  logic sat_exp = 0, stall_prev = 0, done_chk = 0;
  logic [8:0] held;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [7:0] model(input logic [31:0] d, input int sh);
    logic signed [31:0] v;
    v = $signed(d) >>> sh;
    return v < 0 ? 8'd0 : v > 255 ? 8'd255 : v[7:0];
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
      done_chk = 0;
    end else begin
      if (done_chk) begin
        chk("done_after_last", done, 1);
        chk("valid_after_last", out_valid, 0);
        done_chk = 0;
      end
      if (out_valid) begin
        if (stall_prev) chk("hold_stable", {out_last, out_data}, held);
        if (out_ready) begin
          if (q.size() == 0) chk("extra_pixel", 1, 0);
          else begin
            chk("pix_data", out_data, q[0].d);
            chk("pix_last", out_last, q[0].l);
            void'(q.pop_front());
          end
          hs_cnt++;
          if (out_last) done_chk = 1;
        end
        stall_prev = !out_ready;
        held = {out_last, out_data};
      end else stall_prev = 0;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] d, input int gap);
    repeat (gap) tick();
    in_valid = 1;
    in_data = d;
    tick();
    in_valid = 0;
  endtask
  task automatic do_start();
    start = 1;
    tick();
    start = 0;
    sat_exp = 0;
    hs_cnt = 0;
    q.delete();
  endtask
  task automatic frame(input int kind, input bit gaps);
    logic [31:0] d;
    int k;
    for (int p = 0; p < 72; p++)
      for (int t = 0; t < 9; t++) begin
        k = p * 9 + t;
        if (t < 8) d = kind == 0 ? 32'(10 * k) : $urandom;
        else begin
          d = kind == 0 ? 32'(10 * k) : kind == 1 ? (p < 5 ? tbl[p].d : 32'(p)) :
              kind == 2 ? (($urandom % 2) ? $urandom : 32'($urandom_range(0, 300))) : 32'(p + 7);
          q.push_back('{(kind == 1 && p < 5) ? tbl[p].px : model(d, 0), p == 71});
          if ($signed(d) > 255) sat_exp = 1;
        end
        send(d, gaps ? int'($urandom_range(0, 1)) : 0);
        if (kind == 1 && t == 8 && p < 5) chk("sat_tbl", sat, tbl[p].st);
      end
  endtask
  task automatic drain(input int mode);
    int c;
    for (c = 0; c < 3000 && !done; c++) begin
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? ((c >= 10 && c < 15) ? 1'b0 : c[0]) : 1'($urandom_range(0, 1));
      if (mode == 2) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data = $urandom;
      end
      tick();
    end
    in_valid = 0;
    chk("drain_done", done, 1);
    @(negedge clk);
    chk("handshakes", hs_cnt, 72);
    chk("queue_empty", q.size(), 0);
    chk("sat_end", sat, sat_exp);
    chk("busy_done", busy, 0);
  endtask
  initial begin
    tbl[0] = '{32'hFFFFFFFB, 8'd0, 1'b0};
    tbl[1] = '{32'd0, 8'd0, 1'b0};
    tbl[2] = '{32'd255, 8'd255, 1'b0};
    tbl[3] = '{32'd256, 8'd255, 1'b1};
    tbl[4] = '{32'h7FFFFFFF, 8'd255, 1'b1};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {in_ready, out_valid, out_data, out_last, busy, done, sat}, 0);
    tick();
    rst = 0;
    tick();
    chk("idle_busy", busy, 0);
    send(32'd500, 0);
    chk("idle_ignore", {in_ready, busy, done}, 0);
    do_start();
    chk("start_state", {in_ready, busy, done}, 3'b110);
    out_ready = 1;
    frame(0, 0);
    @(negedge clk);
    chk("lat_valid0", out_valid, 0);
    chk("inready_drain", in_ready, 0);
    @(negedge clk);
    chk("lat_valid1", out_valid, 1);
    drain(0);
    do_start();
    chk("sat_cleared", sat, 0);
    frame(1, 0);
    drain(1);
    do_start();
    frame(2, 1);
    chk("inready_after71", in_ready, 0);
    drain(2);
    do_start();
    repeat (300) send(32'd1000, 0);
    chk("partial_sat", sat, 1);
    do_start();
    chk("restart_sat", sat, 0);
    frame(3, 0);
    drain(0);
    do_start();
    repeat (8) send($urandom, 0);
    start = 1;
    in_valid = 1;
    in_data = 32'd200;
    tick();
    start = 0;
    in_valid = 0;
    frame(3, 0);
    drain(0);
    do_start();
    out_ready = 0;
    frame(3, 0);
    for (int c = 0; c < 10 && !out_valid; c++) tick();
    chk("rst_pre_valid", out_valid, 1);
    @(negedge clk);
    #2 rst = 1;
    #1 chk("rst_drain_outs", {in_ready, out_valid, out_data, out_last, busy, done, sat}, 0);
    tick();
    rst = 0;
    q.delete();
    @(negedge clk);
    chk("rst_idle", {in_ready, busy, done, out_valid}, 0);
    s_start = 1;
    tick();
    s_start = 0;
    s_in_valid = 1;
    s_in_data = 32'd4095;
    tick();
    chk("s4_sat0", s_sat, 0);
    s_in_data = 32'd4096;
    tick();
    s_in_valid = 0;
    chk("s4_sat1", s_sat, 1);
    for (int c = 0; c < 10 && !s_out_valid; c++) @(negedge clk);
    chk("s4_px0", {s_out_valid, s_out_last, s_out_data}, {2'b10, 8'd255});
    @(negedge clk);
    chk("s4_px1", {s_out_valid, s_out_last, s_out_data}, {2'b11, 8'd255});
    @(negedge clk);
    chk("s4_done", s_done, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
